// File: rtl/verificador_pkg.sv
// Shared constants for the move-sequence checker: state codes, ROM contents, address width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package verificador_pkg;

  localparam int ADDR_W = 4;
  localparam int DADO_W = 4;

  // State codes double as the db_estado debug value.
  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARACAO = 4'h1,
    ESPERA     = 4'h2,
    REGISTRA   = 4'h3,
    COMPARA    = 4'h4,
    PROXIMO    = 4'h5,
    ACERTOU    = 4'hA,
    ERROU      = 4'hE
  } estado_t;

  // Move sequence; address 0 sits in the least significant nibble.
  localparam logic [63:0] ROM_SEQ = 64'h4188_4422_1124_8421;

  function automatic logic [DADO_W-1:0] rom_ler(input logic [ADDR_W-1:0] addr);
    return ROM_SEQ[{addr, 2'b00} +: DADO_W];
  endfunction

endpackage

// File: rtl/verificador_jogadas_detector_borda.sv
// Rising-edge detector for the play button; one-cycle pulse per press.
// Latency: combinational pulse in the cycle the button is first seen high.
// Backpressure: none; the delayed copy tracks the button every cycle, in every state.
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic jogada,
  output logic jogada_pulso
);

  logic jogada_d;

  // Delayed copy of the button, updated unconditionally so held presses never re-fire.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) jogada_d <= 1'b0;
    else        jogada_d <= jogada;
  end

  assign jogada_pulso = jogada & ~jogada_d;

endmodule

// File: rtl/verificador_jogadas.sv
// Checks player moves against a fixed sequence and reports full match or the failing step.
// Latency: press seen in ESPERA at k -> REGISTRA k+1 -> COMPARA k+2 -> next/terminal k+3.
// Backpressure: presses outside ESPERA are ignored; iniciar only acts in idle/terminal states.
module verificador_jogadas
  import verificador_pkg::*;
#(
  parameter int N = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic [3:0]  chaves,
  input  logic        jogada,
  input  logic        igual,
  output logic [3:0]  dado_esperado,
  output logic [3:0]  dado_jogado,
  output logic        pronto,
  output logic        acertou,
  output logic        errou,
  output logic [3:0]  db_contagem,
  output logic [3:0]  db_estado
);

  localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(N - 1);

  estado_t           estado, proximo;
  logic [ADDR_W-1:0] contagem;
  logic              jogada_pulso;

  detector_borda u_borda (
    .clock        (clock),
    .reset        (reset),
    .jogada       (jogada),
    .jogada_pulso (jogada_pulso)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proximo;
  end

  // Next-state decode; unknown encodings fall back to INICIAL.
  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:    if (iniciar) proximo = PREPARACAO;
      PREPARACAO: proximo = ESPERA;
      ESPERA:     if (jogada_pulso) proximo = REGISTRA;
      REGISTRA:   proximo = COMPARA;
      COMPARA: begin
        if (!igual)                    proximo = ERROU;
        else if (contagem == ULTIMO)   proximo = ACERTOU;
        else                           proximo = PROXIMO;
      end
      PROXIMO:    proximo = ESPERA;
      ACERTOU:    if (iniciar) proximo = PREPARACAO;
      ERROU:      if (iniciar) proximo = PREPARACAO;
      default:    proximo = INICIAL;
    endcase
  end

  // Address counter and captured move; both freeze outside PREPARACAO/PROXIMO/REGISTRA,
  // so a failing pair stays visible in ERROU.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem    <= '0;
      dado_jogado <= '0;
    end else begin
      if (estado == PREPARACAO)   contagem <= '0;
      else if (estado == PROXIMO) contagem <= contagem + 1'b1;

      if (estado == PREPARACAO)     dado_jogado <= '0;
      else if (estado == REGISTRA)  dado_jogado <= chaves;
    end
  end

  assign dado_esperado = rom_ler(contagem);
  assign pronto        = (estado == ACERTOU) || (estado == ERROU);
  assign acertou       = (estado == ACERTOU);
  assign errou         = (estado == ERROU);
  assign db_contagem   = contagem;
  assign db_estado     = estado;

endmodule

// File: tb/tb_verificador_jogadas.sv
// Bench for verificador_jogadas: table of rounds plus hand sequences for button/reset corners.
// Latency: n/a.
// Backpressure: n/a.
module tb_verificador_jogadas;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0, jogada = 1'b0, igual;
  logic       iniciar1 = 1'b0, jogada1 = 1'b0, igual1;
  logic [3:0] chaves = 4'h0;

  logic [3:0] dado_esperado, dado_jogado, db_contagem, db_estado;
  logic       pronto, acertou, errou;
  logic [3:0] dado_esperado1, dado_jogado1, db_contagem1, db_estado1;
  logic       pronto1, acertou1, errou1;

  verificador_jogadas #(.N(16)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .jogada(jogada), .igual(igual),
    .dado_esperado(dado_esperado), .dado_jogado(dado_jogado),
    .pronto(pronto), .acertou(acertou), .errou(errou),
    .db_contagem(db_contagem), .db_estado(db_estado)
  );

  verificador_jogadas #(.N(1)) dut1 (
    .clock(clock), .reset(reset), .iniciar(iniciar1), .chaves(chaves),
    .jogada(jogada1), .igual(igual1),
    .dado_esperado(dado_esperado1), .dado_jogado(dado_jogado1),
    .pronto(pronto1), .acertou(acertou1), .errou(errou1),
    .db_contagem(db_contagem1), .db_estado(db_estado1)
  );

  // External equality comparator beside each instance.
  assign igual  = (dado_esperado  == dado_jogado);
  assign igual1 = (dado_esperado1 == dado_jogado1);

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [3:0] rom_tb [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                              4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

  typedef struct {
    int         err_addr;   // 16 = no error
    logic [3:0] bad;
    logic       exp_acertou;
    logic       exp_errou;
    logic [3:0] exp_cont;
    logic [3:0] exp_esp;
    logic [3:0] exp_jog;
    logic [3:0] exp_estado;
  } vetor_t;

  typedef struct {
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic [3:0] cont;
    logic [3:0] esp;
    logic [3:0] jog;
    logic [3:0] estado;
  } esperado_t;

  vetor_t    tabela [5];
  esperado_t fila [$];

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] req);
    checks++;
    if (atual !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nome, atual, req);
    end
  endtask

  // Called at a negedge in ESPERA; returns cycles until ESPERA again or a terminal state.
  task automatic jogar(input logic [3:0] valor, output int ciclos);
    chaves = valor;
    jogada = 1'b1;
    ciclos = 0;
    do begin
      @(negedge clock);
      ciclos++;
      if (ciclos == 1) jogada = 1'b0;
    end while (!(ciclos > 1 && (db_estado == 4'h2 || pronto)) && ciclos < 20);
  endtask

  task automatic comecar();
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int         c;
    int         ult;
    int         w;
    logic [3:0] v;
    esperado_t  e;
    esperado_t  got;

    tabela[0] = '{16, 4'h0, 1'b1, 1'b0, 4'hF, 4'h4, 4'h4, 4'hA};
    tabela[1] = '{3,  4'h4, 1'b0, 1'b1, 4'h3, 4'h8, 4'h4, 4'hE};
    tabela[2] = '{0,  4'h2, 1'b0, 1'b1, 4'h0, 4'h1, 4'h2, 4'hE};
    tabela[3] = '{15, 4'h1, 1'b0, 1'b1, 4'hF, 4'h4, 4'h1, 4'hE};
    tabela[4] = '{16, 4'h0, 1'b1, 1'b0, 4'hF, 4'h4, 4'h4, 4'hA};

    // Reset values.
    repeat (3) @(negedge clock);
    check("rst_estado", db_estado, 4'h0);
    check("rst_cont", db_contagem, 4'h0);
    check("rst_jogado", dado_jogado, 4'h0);
    check("rst_esperado", dado_esperado, 4'h1);
    check("rst_flags", {pronto, acertou, errou}, 3'b000);
    check("rst_flags_n1", {pronto1, acertou1, errou1}, 3'b000);
    reset = 1'b1;
    @(negedge clock);

    // N=1: first compare is terminal, match then mismatch.
    for (int r = 0; r < 2; r++) begin
      iniciar1 = 1'b1;
      @(negedge clock);
      iniciar1 = 1'b0;
      @(negedge clock);
      chaves = (r == 0) ? 4'h1 : 4'h2;
      jogada1 = 1'b1;
      @(negedge clock);
      jogada1 = 1'b0;
      c = 1;
      while (!pronto1 && c < 20) begin
        @(negedge clock);
        c++;
      end
      check("n1_latencia", c, 3);
      check("n1_acertou", acertou1, (r == 0));
      check("n1_errou", errou1, (r == 1));
      check("n1_estado", db_estado1, (r == 0) ? 4'hA : 4'hE);
      check("n1_cont", db_contagem1, 4'h0);
      check("n1_jogado", dado_jogado1, chaves);
    end

    // Button pressed in INICIAL and still held when ESPERA is entered: not a move.
    chaves = 4'h1;
    jogada = 1'b1;
    repeat (2) @(negedge clock);
    comecar();
    repeat (4) @(negedge clock);
    check("held_start_estado", db_estado, 4'h2);
    check("held_start_cont", db_contagem, 4'h0);
    check("held_start_jogado", dado_jogado, 4'h0);
    jogada = 1'b0;
    @(negedge clock);
    jogar(rom_tb[0], c);
    check("held_start_lat", c, 4);
    check("held_start_cont1", db_contagem, 4'h1);
    check("held_start_jog1", dado_jogado, 4'h1);

    // Button held 20 cycles in ESPERA counts once; iniciar mid-round ignored.
    chaves = rom_tb[1];
    jogada = 1'b1;
    repeat (20) @(negedge clock);
    check("hold_cont", db_contagem, 4'h2);
    check("hold_estado", db_estado, 4'h2);
    jogada = 1'b0;
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    repeat (2) @(negedge clock);
    check("ign_iniciar_cont", db_contagem, 4'h2);
    check("ign_iniciar_estado", db_estado, 4'h2);

    // Advance to address 5, then reset asynchronously in COMPARA.
    for (int m = 2; m < 5; m++) jogar(rom_tb[m], c);
    check("pre_rst_cont", db_contagem, 4'h5);
    chaves = rom_tb[5];
    jogada = 1'b1;
    @(negedge clock);
    jogada = 1'b0;
    @(negedge clock);
    check("pre_rst_compara", db_estado, 4'h4);
    #2 reset = 1'b0;
    #1;
    check("arst_estado", db_estado, 4'h0);
    check("arst_cont", db_contagem, 4'h0);
    check("arst_flags", {pronto, acertou, errou}, 3'b000);
    check("arst_jogado", dado_jogado, 4'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Table of rounds; each starts from INICIAL or the previous terminal state.
    for (int i = 0; i < 5; i++) begin
      comecar();
      check("inicio_estado", db_estado, 4'h2);
      check("inicio_cont", db_contagem, 4'h0);
      check("inicio_flags", {pronto, acertou, errou}, 3'b000);
      e.pronto  = 1'b1;
      e.acertou = tabela[i].exp_acertou;
      e.errou   = tabela[i].exp_errou;
      e.cont    = tabela[i].exp_cont;
      e.esp     = tabela[i].exp_esp;
      e.jog     = tabela[i].exp_jog;
      e.estado  = tabela[i].exp_estado;
      fila.push_back(e);
      ult = (tabela[i].err_addr < 16) ? tabela[i].err_addr : 15;
      for (int m = 0; m <= ult; m++) begin
        v = (m == tabela[i].err_addr) ? tabela[i].bad : rom_tb[m];
        jogar(v, c);
        if (m == ult)      check("latencia_final", c, 3);
        else if (m == 0)   check("latencia_jogada", c, 4);
      end
      w = 0;
      while (!pronto && w < 10) begin
        @(negedge clock);
        w++;
      end
      got.pronto  = pronto;
      got.acertou = acertou;
      got.errou   = errou;
      got.cont    = db_contagem;
      got.esp     = dado_esperado;
      got.jog     = dado_jogado;
      got.estado  = db_estado;
      e = fila.pop_front();
      check("res_pronto", got.pronto, e.pronto);
      check("res_acertou", got.acertou, e.acertou);
      check("res_errou", got.errou, e.errou);
      check("res_cont", got.cont, e.cont);
      check("res_esperado", got.esp, e.esp);
      check("res_jogado", got.jog, e.jog);
      check("res_estado", got.estado, e.estado);
      @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
